// File: rtl/spi_slave_fsm.sv
// Control FSM for the SPI peripheral: frames the address/RW byte, then sequences either a
// memory read into the shift register (driving MISO) or a write commit from it.
module spi_slave_fsm #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         sclkEdge,
  input  logic                         csN,
  input  logic                         rwBit,
  output logic                         shiftRegParallelLoad,
  output logic                         addrLatchEn,
  output logic                         memWriteEn,
  output logic                         misoBufferEn,
  output logic                         busy,
  output logic [$clog2(WIDTH+1)-1:0]   bitCount
);

  localparam int unsigned     CntW     = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntLast  = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] CntFull  = CntW'(WIDTH);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [2:0]      WaitLast = (READ_LATENCY > 1) ? 3'(READ_LATENCY - 2) : 3'd0;

  typedef enum logic [3:0] {
    StIdle,
    StGetAddr,
    StLatchAddr,
    StReadWait,
    StReadLoad,
    StReadShift,
    StWriteShift,
    StWriteCommit,
    StDone
  } stateE;

  stateE           stateQ, stateD;
  logic [CntW-1:0] bitCountD;
  logic [2:0]      waitCntQ, waitCntD;

  always_comb begin
    stateD    = stateQ;
    bitCountD = bitCount;
    waitCntD  = waitCntQ;
    // Chip-select release wins over everything, including a same-cycle final edge.
    if (stateQ != StIdle && csN) begin
      stateD    = StIdle;
      bitCountD = '0;
      waitCntD  = '0;
    end else begin
      case (stateQ)
        StIdle: begin
          if (!csN) begin
            stateD    = StGetAddr;
            bitCountD = '0;
          end
        end
        StGetAddr: begin
          if (sclkEdge) begin
            bitCountD = (bitCount == CntFull) ? bitCount : bitCount + CntOne;
            if (bitCount == CntLast) stateD = StLatchAddr;
          end
        end
        StLatchAddr: begin
          bitCountD = '0;
          waitCntD  = '0;
          if (rwBit) stateD = (READ_LATENCY > 1) ? StReadWait : StReadLoad;
          else       stateD = StWriteShift;
        end
        StReadWait: begin
          if (waitCntQ == WaitLast) stateD = StReadLoad;
          else                      waitCntD = waitCntQ + 3'd1;
        end
        StReadLoad: stateD = StReadShift;
        StReadShift: begin
          if (sclkEdge) begin
            bitCountD = (bitCount == CntFull) ? bitCount : bitCount + CntOne;
            if (bitCount == CntLast) stateD = StDone;
          end
        end
        StWriteShift: begin
          if (sclkEdge) begin
            bitCountD = (bitCount == CntFull) ? bitCount : bitCount + CntOne;
            if (bitCount == CntLast) stateD = StWriteCommit;
          end
        end
        StWriteCommit: stateD = StDone;
        StDone:        stateD = StDone;
        default:       stateD = StIdle;
      endcase
    end
  end

  // Outputs are decoded from the next state so each one is a clean register (Moore).
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      stateQ               <= StIdle;
      bitCount             <= '0;
      waitCntQ             <= '0;
      addrLatchEn          <= 1'b0;
      shiftRegParallelLoad <= 1'b0;
      memWriteEn           <= 1'b0;
      misoBufferEn         <= 1'b0;
      busy                 <= 1'b0;
    end else begin
      stateQ               <= stateD;
      bitCount             <= bitCountD;
      waitCntQ             <= waitCntD;
      addrLatchEn          <= (stateD == StLatchAddr);
      shiftRegParallelLoad <= (stateD == StReadLoad);
      memWriteEn           <= (stateD == StWriteCommit);
      misoBufferEn         <= (stateD == StReadShift);
      busy                 <= (stateD != StIdle);
    end
  end

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Scoreboarded bench for spi_slave_fsm: two instances (read latency 1 and 3) share one
// randomized frame stream; a frame-level model predicts every output event in advance.
module tb_spi_slave_fsm;

  logic       clk      = 1'b0;
  logic       resetN   = 1'b1;
  logic       sclkEdge = 1'b0;
  logic       csN      = 1'b1;
  logic       rwBit    = 1'b0;
  logic       ld1, ale1, mw1, miso1, busy1;
  logic       ld3, ale3, mw3, miso3, busy3;
  logic [3:0] bc1, bc3;

  int cyc    = 0;
  int tests  = 0;
  int errors = 0;
  int q1[$];
  int q3[$];

  int frCsLow;
  int frEnd;
  bit frRw;
  int frEdges[$];

  spi_slave_fsm #(.WIDTH(8), .READ_LATENCY(1)) dut1 (
    .clk                 (clk),
    .resetN              (resetN),
    .sclkEdge            (sclkEdge),
    .csN                 (csN),
    .rwBit               (rwBit),
    .shiftRegParallelLoad(ld1),
    .addrLatchEn         (ale1),
    .memWriteEn          (mw1),
    .misoBufferEn        (miso1),
    .busy                (busy1),
    .bitCount            (bc1)
  );

  spi_slave_fsm #(.WIDTH(8), .READ_LATENCY(3)) dut3 (
    .clk                 (clk),
    .resetN              (resetN),
    .sclkEdge            (sclkEdge),
    .csN                 (csN),
    .rwBit               (rwBit),
    .shiftRegParallelLoad(ld3),
    .addrLatchEn         (ale3),
    .memWriteEn          (mw3),
    .misoBufferEn        (miso3),
    .busy                (busy3),
    .bitCount            (bc3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event kinds; a key is cycle*8+kind, so sorting keys orders same-cycle events by kind.
  function automatic string kname(input int k);
    case (k)
      0:       return "busyRise";
      1:       return "addrLatch";
      2:       return "parLoad";
      3:       return "misoRise";
      4:       return "misoFall";
      5:       return "memWrite";
      6:       return "busyFall";
      default: return "unknown";
    endcase
  endfunction

  // Frame-level expectation: which events a frame yields, and on which cycle, given the
  // cycles at which csN went low, each SCLK edge was sampled, and the frame ended.
  function automatic void model(input int lat, input int which);
    int ev[$];
    int n, a, fallC;
    n = frEdges.size();
    ev.push_back(frCsLow * 8 + 0);
    if (n >= 8 && frEdges[7] < frEnd) begin
      a = frEdges[7];
      ev.push_back(a * 8 + 1);
      if (frRw) begin
        if (a + lat < frEnd) ev.push_back((a + lat) * 8 + 2);
        if (a + lat + 1 < frEnd) begin
          ev.push_back((a + lat + 1) * 8 + 3);
          fallC = (n >= 16 && frEdges[15] < frEnd) ? frEdges[15] : frEnd;
          ev.push_back(fallC * 8 + 4);
        end
      end else if (n >= 16 && frEdges[15] < frEnd) begin
        ev.push_back(frEdges[15] * 8 + 5);
      end
    end
    ev.push_back(frEnd * 8 + 6);
    ev.sort();
    foreach (ev[i]) begin
      if (which == 0) q1.push_back(ev[i]);
      else            q3.push_back(ev[i]);
    end
  endfunction

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
    end
  endtask

  task automatic seeEvent(input int which, input int kind);
    int key, exp, lat;
    key = cyc * 8 + kind;
    lat = (which == 0) ? 1 : 3;
    if (which == 0 && q1.size() > 0)      exp = q1.pop_front();
    else if (which == 1 && q3.size() > 0) exp = q3.pop_front();
    else                                  exp = -1;
    tests++;
    if (exp != key) begin
      errors++;
      if (exp < 0)
        $display("FAIL event lat%0d: got %s@%0d, expected no event", lat, kname(kind), cyc);
      else
        $display("FAIL event lat%0d: got %s@%0d, expected %s@%0d", lat, kname(kind), cyc,
                 kname(exp % 8), exp / 8);
    end
  endtask

  // Monitor: turns output pulses and level changes into events and pops the scoreboard.
  logic pm1 = 1'b0, pb1 = 1'b0, pm3 = 1'b0, pb3 = 1'b0;
  always @(negedge clk) begin
    if (busy1 && !pb1)  seeEvent(0, 0);
    if (ale1)           seeEvent(0, 1);
    if (ld1)            seeEvent(0, 2);
    if (miso1 && !pm1)  seeEvent(0, 3);
    if (!miso1 && pm1)  seeEvent(0, 4);
    if (mw1)            seeEvent(0, 5);
    if (!busy1 && pb1)  seeEvent(0, 6);
    if (busy3 && !pb3)  seeEvent(1, 0);
    if (ale3)           seeEvent(1, 1);
    if (ld3)            seeEvent(1, 2);
    if (miso3 && !pm3)  seeEvent(1, 3);
    if (!miso3 && pm3)  seeEvent(1, 4);
    if (mw3)            seeEvent(1, 5);
    if (!busy3 && pb3)  seeEvent(1, 6);
    pm1 <= miso1;
    pb1 <= busy1;
    pm3 <= miso3;
    pb3 <= busy3;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 normal end, 1 csN abort after nEdges, 2 csN rises with edge nEdges,
  // 3 async reset two cycles after edge nEdges.
  task automatic runFrame(input bit rw, input int nEdges, input int kind, input int extra);
    int s, t, endC, ei;
    s       = cyc;
    frCsLow = s + 1;
    frRw    = rw;
    frEdges.delete();
    t = frCsLow + int'($urandom_range(4, 1));
    for (int i = 0; i < nEdges + extra; i++) begin
      frEdges.push_back(t);
      t += int'($urandom_range(9, 6));
    end
    case (kind)
      0:       endC = frEdges[frEdges.size()-1] + int'($urandom_range(5, 2));
      1:       endC = ((nEdges > 0) ? frEdges[nEdges-1] : frCsLow) + int'($urandom_range(5, 1));
      2:       endC = frEdges[nEdges-1];
      default: endC = frEdges[nEdges-1] + 2;
    endcase
    frEnd = endC;
    model(1, 0);
    model(3, 1);
    ei = 0;
    for (int t2 = s + 1; t2 <= endC; t2++) begin
      csN      = !(t2 >= frCsLow && (t2 < endC || kind == 3));
      sclkEdge = (ei < frEdges.size() && frEdges[ei] == t2);
      if (sclkEdge) ei++;
      rwBit = rw;
      tick();
      if (t2 == frCsLow) begin
        check("start busy L1", int'(busy1), 1);
        check("start busy L3", int'(busy3), 1);
        check("start bitCount L1", int'(bc1), 0);
        check("start bitCount L3", int'(bc3), 0);
      end
      if (kind == 0 && t2 == endC - 1) begin
        check("done bitCount L1", int'(bc1), 8);
        check("done bitCount L3", int'(bc3), 8);
        check("done busy L1", int'(busy1), 1);
        check("done busy L3", int'(busy3), 1);
      end
      if ((kind == 1 || kind == 2) && t2 == endC) begin
        check("abort busy L1", int'(busy1), 0);
        check("abort busy L3", int'(busy3), 0);
        check("abort bitCount L1", int'(bc1), 0);
        check("abort bitCount L3", int'(bc3), 0);
      end
      if (kind == 3 && t2 == endC) begin
        check("pre-reset miso L1", int'(miso1), 1);
        check("pre-reset miso L3", int'(miso3), 1);
        #1 resetN = 1'b0;
        #1;
        check("async reset miso L1", int'(miso1), 0);
        check("async reset miso L3", int'(miso3), 0);
        check("async reset busy L1", int'(busy1), 0);
        check("async reset busy L3", int'(busy3), 0);
      end
    end
    sclkEdge = 1'b0;
    csN      = 1'b1;
    rwBit    = 1'($urandom);
    if (kind == 3) begin
      tick();
      resetN = 1'b1;
    end
    repeat (2) tick();
  endtask

  initial begin
    logic [7:0] addrByte;
    int         k;
    #1 resetN = 1'b0;
    repeat (3) tick();
    check("reset outputs L1", int'({ale1, ld1, mw1, miso1, busy1, bc1}), 0);
    check("reset outputs L3", int'({ale3, ld3, mw3, miso3, busy3, bc3}), 0);
    resetN = 1'b1;
    repeat (2) tick();

    addrByte = 8'h54;
    runFrame(addrByte[0], 16, 0, 0);  // write frame
    addrByte = 8'h55;
    runFrame(addrByte[0], 16, 0, 3);  // read frame, extra edges in DONE
    runFrame(1'b0, 13, 1, 0);         // abort after 5 write-data edges
    runFrame(1'b0, 8, 2, 0);          // csN rises with the 8th address edge
    runFrame(1'b1, 10, 3, 0);         // async reset during READ_SHIFT

    for (int f = 0; f < 40; f++) begin
      k = int'($urandom_range(9, 0));
      if (k <= 4)      runFrame(1'($urandom), 16, 0, int'($urandom_range(3, 0)));
      else if (k <= 7) runFrame(1'($urandom), int'($urandom_range(15, 0)), 1, 0);
      else if (k == 8) runFrame(1'($urandom), int'($urandom_range(16, 1)), 2, 0);
      else             runFrame(1'b1, 10, 3, 0);
    end

    repeat (5) tick();
    check("leftover events L1", q1.size(), 0);
    check("leftover events L3", q3.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
